// File: rtl/tdt_dmi_apb_master_if.sv
// DMI transport request/response channel and APB3 bus toward the debug module.
// The master modport is the initiator's view; slave is the environment's view.
interface tdt_dmi_apb_master_if #(
    parameter int ADDR_W = 12
);
    logic              dtm_dmi_req_vld;
    logic              dtm_dmi_req_rdy;
    logic [1:0]        dtm_dmi_req_op;
    logic [ADDR_W-1:0] dtm_dmi_req_addr;
    logic [31:0]       dtm_dmi_req_wdata;
    logic              dtm_dmi_rsp_vld;
    logic              dtm_dmi_rsp_rdy;
    logic [31:0]       dtm_dmi_rsp_data;
    logic [1:0]        dtm_dmi_rsp_stat;
    logic              dtm_dmi_err_clr;
    logic              dtm_dmi_sticky_err;

    logic [ADDR_W-1:0] tdt_dmi_paddr;
    logic              tdt_dmi_psel;
    logic              tdt_dmi_penable;
    logic              tdt_dmi_pwrite;
    logic [31:0]       tdt_dmi_pwdata;
    logic [31:0]       tdt_dmi_prdata;
    logic              tdt_dmi_pready;
    logic              tdt_dmi_pslverr;

    modport master (
        input  dtm_dmi_req_vld,
        output dtm_dmi_req_rdy,
        input  dtm_dmi_req_op,
        input  dtm_dmi_req_addr,
        input  dtm_dmi_req_wdata,
        output dtm_dmi_rsp_vld,
        input  dtm_dmi_rsp_rdy,
        output dtm_dmi_rsp_data,
        output dtm_dmi_rsp_stat,
        input  dtm_dmi_err_clr,
        output dtm_dmi_sticky_err,
        output tdt_dmi_paddr,
        output tdt_dmi_psel,
        output tdt_dmi_penable,
        output tdt_dmi_pwrite,
        output tdt_dmi_pwdata,
        input  tdt_dmi_prdata,
        input  tdt_dmi_pready,
        input  tdt_dmi_pslverr
    );

    modport slave (
        output dtm_dmi_req_vld,
        input  dtm_dmi_req_rdy,
        output dtm_dmi_req_op,
        output dtm_dmi_req_addr,
        output dtm_dmi_req_wdata,
        input  dtm_dmi_rsp_vld,
        output dtm_dmi_rsp_rdy,
        input  dtm_dmi_rsp_data,
        input  dtm_dmi_rsp_stat,
        output dtm_dmi_err_clr,
        input  dtm_dmi_sticky_err,
        input  tdt_dmi_paddr,
        input  tdt_dmi_psel,
        input  tdt_dmi_penable,
        input  tdt_dmi_pwrite,
        input  tdt_dmi_pwdata,
        output tdt_dmi_prdata,
        output tdt_dmi_pready,
        output tdt_dmi_pslverr
    );
endinterface

// File: rtl/tdt_dmi_apb_master.sv
// DMI initiator: one debug-transport request at a time issued as an APB3 transfer,
// with ready-timeout and dmistat-style sticky error.
module tdt_dmi_apb_master #(
    parameter int ADDR_W = 12,
    parameter int TO_W   = 8,
    parameter int TO_CYC = 200
) (
    input  logic                 sys_apb_clk,
    input  logic                 sys_apb_rst,
    tdt_dmi_apb_master_if.master dmi
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_RD    = 2'd1;
    localparam logic [1:0] OP_WR    = 2'd2;

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_FAIL  = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TO_CYC == 0) ? 0 : TO_CYC - 1);

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [TO_W-1:0]   to_cnt;
    logic [31:0]       rsp_data_q;
    logic [1:0]        rsp_stat_q;
    logic              rsp_vld_q;
    logic              sticky_q;

    logic              req_fire;
    logic              op_rw;
    logic              op_nop;
    logic              idle_go;
    logic [1:0]        idle_stat;
    logic              to_hit;
    logic              acc_done;
    logic [1:0]        acc_stat;
    logic [31:0]       acc_data;
    logic              set_err;

    assign req_fire = (state == S_IDLE) && dmi.dtm_dmi_req_vld;
    assign op_rw    = (dmi.dtm_dmi_req_op == OP_RD) ||
                      (dmi.dtm_dmi_req_op == OP_WR);
    assign op_nop   = (dmi.dtm_dmi_req_op == OP_NOP);

    // Only a clean read/write reaches the bus; everything else answers at once.
    always_comb begin
        idle_go   = 1'b0;
        idle_stat = ST_FAIL;
        unique case (1'b1)
            op_rw && !sticky_q:  idle_go   = 1'b1;
            op_nop && !sticky_q: idle_stat = ST_OK;
            default:             idle_stat = ST_FAIL;
        endcase
    end

    assign to_hit   = (TO_CYC != 0) && (to_cnt == TO_LAST);
    assign acc_done = (state == S_ACCESS) &&
                      (dmi.tdt_dmi_pready || to_hit);

    // pready wins over a timeout landing in the same cycle.
    always_comb begin
        acc_stat = ST_FAIL;
        acc_data = 32'd0;
        if (dmi.tdt_dmi_pready && !dmi.tdt_dmi_pslverr) begin
            acc_stat = ST_OK;
            if (op_q == OP_RD) begin
                acc_data = dmi.tdt_dmi_prdata;
            end
        end
    end

    assign set_err = (req_fire && !idle_go && (idle_stat == ST_FAIL)) ||
                     (acc_done && (acc_stat == ST_FAIL));

    always_ff @(posedge sys_apb_clk or posedge sys_apb_rst) begin
        if (sys_apb_rst) begin
            state      <= S_IDLE;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            to_cnt     <= '0;
            rsp_data_q <= 32'd0;
            rsp_stat_q <= ST_OK;
            rsp_vld_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_fire) begin
                        op_q       <= dmi.dtm_dmi_req_op;
                        addr_q     <= dmi.dtm_dmi_req_addr;
                        wdata_q    <= dmi.dtm_dmi_req_wdata;
                        to_cnt     <= '0;
                        rsp_data_q <= 32'd0;
                        if (idle_go) begin
                            state <= S_SETUP;
                        end else begin
                            state      <= S_RESP;
                            rsp_vld_q  <= 1'b1;
                            rsp_stat_q <= idle_stat;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (acc_done) begin
                        state      <= S_RESP;
                        rsp_vld_q  <= 1'b1;
                        rsp_stat_q <= acc_stat;
                        rsp_data_q <= acc_data;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    if (dmi.dtm_dmi_rsp_rdy) begin
                        state     <= S_IDLE;
                        rsp_vld_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A new error outranks a clear arriving in the same cycle.
    always_ff @(posedge sys_apb_clk or posedge sys_apb_rst) begin
        if (sys_apb_rst) begin
            sticky_q <= 1'b0;
        end else if (set_err) begin
            sticky_q <= 1'b1;
        end else if (dmi.dtm_dmi_err_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign dmi.dtm_dmi_req_rdy    = (state == S_IDLE);
    assign dmi.dtm_dmi_rsp_vld    = rsp_vld_q;
    assign dmi.dtm_dmi_rsp_data   = rsp_data_q;
    assign dmi.dtm_dmi_rsp_stat   = rsp_stat_q;
    assign dmi.dtm_dmi_sticky_err = sticky_q;

    assign dmi.tdt_dmi_psel    = (state == S_SETUP) || (state == S_ACCESS);
    assign dmi.tdt_dmi_penable = (state == S_ACCESS);
    assign dmi.tdt_dmi_paddr   = addr_q;
    assign dmi.tdt_dmi_pwrite  = (op_q == OP_WR);
    assign dmi.tdt_dmi_pwdata  = wdata_q;
endmodule

// File: tb/tb_tdt_dmi_apb_master.sv
// Scoreboard bench for tdt_dmi_apb_master with a behavioural APB slave.
module tb_tdt_dmi_apb_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdt_dmi_apb_master_if #(.ADDR_W(12)) dmi ();

    tdt_dmi_apb_master #(
        .ADDR_W(12),
        .TO_W  (8),
        .TO_CYC(4)
    ) dut (
        .sys_apb_clk(clk),
        .sys_apb_rst(rst),
        .dmi        (dmi)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  stat;
    } rsp_t;

    rsp_t sb[$];
    rsp_t exp_r;

    int n_chk = 0;
    int n_pass = 0;
    int psel_cnt = 0;
    int pen_cnt = 0;
    int stab_bad = 0;
    int acc_cyc = 0;

    logic [11:0] mon_addr = '0;
    logic [31:0] mon_wdata = '0;
    logic        mon_write = 1'b0;

    int          slave_wait = 0;
    logic        slave_err = 1'b0;
    logic        slave_hang = 1'b0;
    logic [31:0] slave_rdata = '0;

    assign dmi.tdt_dmi_pready  = dmi.tdt_dmi_penable && !slave_hang &&
                                 (acc_cyc > slave_wait);
    assign dmi.tdt_dmi_pslverr = dmi.tdt_dmi_pready && slave_err;
    assign dmi.tdt_dmi_prdata  = slave_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (dmi.tdt_dmi_penable) acc_cyc = acc_cyc + 1;
        else acc_cyc = 0;
        if (dmi.tdt_dmi_psel) begin
            psel_cnt++;
            if (dmi.tdt_dmi_penable) pen_cnt++;
            if (dmi.tdt_dmi_paddr !== mon_addr ||
                dmi.tdt_dmi_pwdata !== mon_wdata ||
                dmi.tdt_dmi_pwrite !== mon_write) stab_bad++;
        end
        if (dmi.dtm_dmi_rsp_vld && dmi.dtm_dmi_rsp_rdy) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_r = sb.pop_front();
                chk("rsp_data", dmi.dtm_dmi_rsp_data, exp_r.data);
                chk("rsp_stat", {30'd0, dmi.dtm_dmi_rsp_stat},
                    {30'd0, exp_r.stat});
            end
        end
    end

    task automatic drive_req(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wd);
        bit ok = 0;
        mon_addr  = addr;
        mon_wdata = wd;
        mon_write = (op == 2'd2);
        dmi.dtm_dmi_req_op    = op;
        dmi.dtm_dmi_req_addr  = addr;
        dmi.dtm_dmi_req_wdata = wd;
        dmi.dtm_dmi_req_vld   = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (dmi.dtm_dmi_req_rdy) ok = 1;
            @(posedge clk);
            #1;
        end
        dmi.dtm_dmi_req_vld = 1'b0;
        chk("req_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] ed,
                        input logic [1:0] es);
        sb.push_back(rsp_t'{data: ed, stat: es});
        drive_req(op, addr, wd);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err();
        dmi.dtm_dmi_err_clr = 1'b1;
        @(posedge clk);
        #1;
        dmi.dtm_dmi_err_clr = 1'b0;
    endtask

    initial begin
        int p;
        int n;
        dmi.dtm_dmi_req_vld   = 1'b0;
        dmi.dtm_dmi_req_op    = 2'd0;
        dmi.dtm_dmi_req_addr  = '0;
        dmi.dtm_dmi_req_wdata = '0;
        dmi.dtm_dmi_rsp_rdy   = 1'b1;
        dmi.dtm_dmi_err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy", {31'd0, dmi.dtm_dmi_req_rdy}, 32'd1);
        chk("rst_bus", {28'd0, dmi.tdt_dmi_psel, dmi.tdt_dmi_penable,
            dmi.dtm_dmi_rsp_vld, dmi.dtm_dmi_sticky_err}, 32'd0);
        chk("rst_paddr", {20'd0, dmi.tdt_dmi_paddr}, 32'd0);
        chk("rst_rdata", dmi.dtm_dmi_rsp_data, 32'd0);
        rst = 1'b0;

        // single-cycle read, latency profile
        slave_rdata = 32'hDEAD_BEEF;
        send(2'd1, 12'h010, 32'd0, 32'hDEAD_BEEF, 2'd0);
        @(negedge clk);
        chk("t1_setup", {30'd0, dmi.tdt_dmi_psel, dmi.tdt_dmi_penable}, 32'd2);
        @(negedge clk);
        chk("t1_access", {30'd0, dmi.tdt_dmi_psel, dmi.tdt_dmi_penable}, 32'd3);
        @(negedge clk);
        chk("t1_rsp", {30'd0, dmi.dtm_dmi_rsp_vld, dmi.tdt_dmi_psel}, 32'd2);
        wait_done();

        // write with wait states
        slave_wait = 3;
        p = pen_cnt;
        stab_bad = 0;
        send(2'd2, 12'h044, 32'd1, 32'd0, 2'd0);
        wait_done();
        chk("t2_penable", pen_cnt - p, 32'd4);
        chk("t2_stable", stab_bad, 32'd0);
        slave_wait = 0;

        // slave error, sticky blocking, nop/op3, clear
        slave_err = 1'b1;
        send(2'd1, 12'h020, 32'd0, 32'd0, 2'd2);
        wait_done();
        chk("t3_sticky", {31'd0, dmi.dtm_dmi_sticky_err}, 32'd1);
        slave_err = 1'b0;
        p = psel_cnt;
        send(2'd2, 12'h024, 32'd7, 32'd0, 2'd2);
        wait_done();
        send(2'd0, 12'h000, 32'd0, 32'd0, 2'd2);
        wait_done();
        chk("t3_nopsel", psel_cnt - p, 32'd0);
        clear_err();
        chk("t3_clr", {31'd0, dmi.dtm_dmi_sticky_err}, 32'd0);
        p = psel_cnt;
        send(2'd2, 12'h024, 32'd7, 32'd0, 2'd0);
        wait_done();
        chk("t3_apb", psel_cnt - p, 32'd2);
        send(2'd0, 12'h008, 32'd0, 32'd0, 2'd0);
        wait_done();
        p = psel_cnt;
        send(2'd3, 12'h008, 32'd0, 32'd0, 2'd2);
        wait_done();
        chk("op3_nopsel", psel_cnt - p, 32'd0);
        chk("op3_sticky", {31'd0, dmi.dtm_dmi_sticky_err}, 32'd1);
        clear_err();

        // ready timeout
        slave_hang = 1'b1;
        p = pen_cnt;
        send(2'd1, 12'h030, 32'd0, 32'd0, 2'd2);
        wait_done();
        chk("t4_penable", pen_cnt - p, 32'd4);
        chk("t4_sticky", {31'd0, dmi.dtm_dmi_sticky_err}, 32'd1);
        slave_hang = 1'b0;
        clear_err();

        // response back-pressure with a pending request
        dmi.dtm_dmi_rsp_rdy = 1'b0;
        slave_rdata = 32'h1234_5678;
        send(2'd1, 12'h034, 32'd0, 32'h1234_5678, 2'd0);
        n = 0;
        while (!dmi.dtm_dmi_rsp_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_vld", {31'd0, dmi.dtm_dmi_rsp_vld}, 32'd1);
        sb.push_back(rsp_t'{data: 32'd0, stat: 2'd0});
        dmi.dtm_dmi_req_op    = 2'd2;
        dmi.dtm_dmi_req_addr  = 12'h048;
        dmi.dtm_dmi_req_wdata = 32'd5;
        dmi.dtm_dmi_req_vld   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_req_rdy", {31'd0, dmi.dtm_dmi_req_rdy}, 32'd0);
            chk("t5_hold", dmi.dtm_dmi_rsp_data, 32'h1234_5678);
        end
        @(posedge clk);
        #1;
        dmi.dtm_dmi_rsp_rdy = 1'b1;
        drive_req(2'd2, 12'h048, 32'd5);
        wait_done();

        // async reset in ACCESS
        slave_hang = 1'b1;
        drive_req(2'd1, 12'h050, 32'd0);
        n = 0;
        while (!dmi.tdt_dmi_penable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_access", {31'd0, dmi.tdt_dmi_penable}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_drop", {29'd0, dmi.tdt_dmi_psel, dmi.tdt_dmi_penable,
            dmi.dtm_dmi_rsp_vld}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        slave_hang = 1'b0;
        @(negedge clk);
        chk("t6_req_rdy", {31'd0, dmi.dtm_dmi_req_rdy}, 32'd1);
        slave_rdata = 32'h0000_A5A5;
        send(2'd1, 12'h060, 32'd0, 32'h0000_A5A5, 2'd0);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
